// File: rtl/thresh_event_fifo.sv
// Timestamps rising threshold crossings on two DAC channels and queues them for host readout.
// Words are {6'b0, hit_mask[1:0], timestamp[23:0]}; overflow is sticky and drops are counted.
module thresh_event_fifo #(
  parameter int          DEPTH   = 64,
  parameter int          AW      = 6,
  parameter logic [23:0] TS_INIT = 24'h0  // timestamp value after reset/clear
) (
  input  logic          dataclk,
  input  logic          reset,
  input  logic          sample_CLK,
  input  logic [1:0]    thresh_in,
  input  logic          enable,
  input  logic          clear,
  input  logic [15:0]   refractory,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   drop_count
);

  logic          r_sclk, r_sclk_prev;
  logic [1:0]    r_thresh, r_thresh_prev;
  logic [15:0]   r_refr [2];
  logic [23:0]   r_ts;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [25:0]   r_mem [DEPTH];

  logic          w_tick;
  logic [1:0]    w_hit;
  logic          w_event, w_do_wr, w_do_rd, w_drop;
  logic [AW:0]   w_count_nxt;

  assign w_tick = r_sclk & ~r_sclk_prev;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_hit = 2'b00;
    for (int k = 0; k < 2; k++)
      w_hit[k] = w_tick & enable & r_thresh[k] & ~r_thresh_prev[k] & (r_refr[k] == 16'd0);
  end

  assign w_event = |w_hit;
  assign w_do_rd = rd_en & ~empty;
  // When full, a concurrent pop frees the slot the write needs.
  assign w_do_wr = w_event & (~full | rd_en);
  assign w_drop  = w_event & ~w_do_wr;

  always_comb begin
    w_count_nxt = count;
    case ({w_do_wr, w_do_rd})
      2'b10:   w_count_nxt = count + (AW+1)'(1);
      2'b01:   w_count_nxt = count - (AW+1)'(1);
      default: w_count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      r_sclk        <= 1'b0;
      r_sclk_prev   <= 1'b0;
      r_thresh      <= 2'b00;
      r_thresh_prev <= 2'b00;
      r_refr[0]     <= 16'd0;
      r_refr[1]     <= 16'd0;
      r_ts          <= TS_INIT;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      rd_data       <= 32'd0;
      rd_valid      <= 1'b0;
      empty         <= 1'b1;
      full          <= 1'b0;
      count         <= '0;
      overflow      <= 1'b0;
      drop_count    <= 16'd0;
    end else if (clear) begin
      r_sclk        <= 1'b0;
      r_sclk_prev   <= 1'b0;
      r_thresh      <= 2'b00;
      r_thresh_prev <= 2'b00;
      r_refr[0]     <= 16'd0;
      r_refr[1]     <= 16'd0;
      r_ts          <= TS_INIT;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      rd_valid      <= 1'b0;
      empty         <= 1'b1;
      full          <= 1'b0;
      count         <= '0;
      overflow      <= 1'b0;
      drop_count    <= 16'd0;
    end else begin
      r_sclk      <= sample_CLK;
      r_sclk_prev <= r_sclk;
      r_thresh    <= thresh_in;
      if (w_tick) begin
        r_ts          <= r_ts + 24'd1;
        r_thresh_prev <= r_thresh;
        for (int k = 0; k < 2; k++) begin
          if (w_hit[k])                r_refr[k] <= refractory;
          else if (r_refr[k] != 16'd0) r_refr[k] <= r_refr[k] - 16'd1;
        end
      end
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) begin
        rd_data  <= {6'b0, r_mem[r_rd_ptr]};
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      rd_valid <= w_do_rd;
      count    <= w_count_nxt;
      empty    <= (w_count_nxt == '0);
      full     <= (w_count_nxt == (AW+1)'(DEPTH));
      if (w_drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // NOTE: storage has no reset; pointers and count define which entries are meaningful.
  always_ff @(posedge dataclk) begin
    if (w_do_wr && !clear) r_mem[r_wr_ptr] <= {w_hit, r_ts};
  end

endmodule

// File: doc/thresh_event_fifo.md
# thresh_event_fifo

Downstream consumer of the DAC threshold stage's `DAC_thresh_out` and `sample_CLK_out`: timestamps rising threshold crossings on both DAC channels and queues them in a FIFO for host readout. Timestamp is a free-running per-sample counter, so host software can reconstruct spike times against the amplifier sample stream. Per-channel refractory lockout suppresses re-triggering on a single spike waveform. Overflow is flagged and counted, never silently lost.

## Interface
- `DEPTH`, 64: FIFO entries; power of two, 4..1024.
- `AW`, 6: log2(DEPTH).
- `dataclk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; block held in reset while 0.
- `sample_CLK`  in  1  from `sample_CLK_out`; rising edge marks a new sample.
- `thresh_in`  in  2  from `DAC_thresh_out`; bit k = channel k above threshold.
- `enable`  in  1  1 = record events.
- `clear`  in  1  synchronous clear of FIFO, timestamp, flags, refractory.
- `refractory`  in  16  lockout length in samples after an accepted event; 0 = none.
- `rd_en`  in  1  pop request.
- `rd_data`  out  32  {6'b0, hit_mask[1:0], timestamp[23:0]}.
- `rd_valid`  out  1  one-cycle pulse, `rd_data` valid.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  AW+1  entries stored.
- `overflow`  out  1  sticky: an event was dropped.
- `drop_count`  out  16  dropped events, saturates at 65535.

## Operation
- Reset values: `rd_data`=0, `rd_valid`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `drop_count`=0; timestamp, refractory counters and edge-detect history all 0.
- Tick: `sample_CLK` registered once; tick = registered 1 and previous 0, one `dataclk` wide. `thresh_in` captured on the same edge as the sample_CLK register.
- Timestamp: 24-bit, increments on every tick regardless of `enable`; wraps 0xFFFFFF -> 0. First sample after reset/clear carries timestamp 0.
- Hit on channel k at a tick: captured thresh[k]=1, previous-tick thresh[k]=0, refractory counter k = 0.
- Previous-tick thresh history updates every tick, including while `enable`=0.
- Refractory counter k loads `refractory` on a hit for k; decrements by 1 each tick while nonzero; not reloaded by held-high thresh.
- Event: `enable`=1 and hit_mask != 0. One word per tick; simultaneous hits -> mask 2'b11 in one word. `enable`=0: no hits, refractory not loaded.
- Write accepted when !`full` or (`full` and `rd_en`). Otherwise dropped: `overflow`<=1, `drop_count`+1 saturating; refractory still loaded.
- Read: `rd_en` with !`empty` pops head; `rd_data` registered, `rd_valid` pulses. `rd_en` while empty ignored, no pulse, `rd_data` holds.
- Simultaneous read and write: both happen, `count` unchanged. Read of empty concurrent with write: read ignored, write proceeds.
- `clear`=1: same state as reset except `rd_data` holds; has priority over tick, write and read that cycle.
- Reset mid-operation: immediate return to reset values; FIFO contents discarded.

## Timing
- sample_CLK sampled high at edge E (low at E-1): tick high in cycle after E; FIFO write, timestamp increment, refractory load/decrement on edge E+1. Entry timestamp = pre-increment value.
- `count`, `empty`, `full` registered; reflect write/read after the same edge.
- Read latency 1: `rd_en` sampled at edge R -> `rd_data`/`rd_valid` valid after R, `rd_valid` low after R+1 unless popped again.
- Back-to-back `rd_en` each cycle drains one word per cycle.
- Minimum tick spacing 2 dataclk cycles; main_reduced's sample rate is far below this.

## Test plan
- Reset, 5 ticks with `thresh_in`=0, then ch0 rises before tick 6 -> one word 0x01000005, `count`=1.
- `refractory`=3, ch1 pulses high one tick every tick-pair for 10 ticks from ts 0 -> words at ts 0, 4, 8 only, mask 2'b10.
- Both channels rise on same tick at ts 0x20 -> single word 0x03000020.
- DEPTH=64, 70 events, no reads -> `full`=1, `overflow`=1, `drop_count`=6, first 64 timestamps read back in order.
- Full FIFO, `rd_en` on write cycle -> write accepted, `count` stays 64, `drop_count` unchanged; `rd_en` on empty -> no `rd_valid`.
- Timestamp preset near wrap: events at 0xFFFFFF then 0x000000 -> both words correct; `reset` pulled low mid-burst -> all outputs at reset values next cycle.
